ibex_data_bus_arbiter: RTL and testbench
========================================

Name: ibex_data_bus_arbiter

Overview:
- Shares the single core data-memory port (req/gnt/rvalid protocol) between two requesters, e.g. the LSU (m0) and a debug/DMA master (m1).
- Round-robin arbitration; a granted but not-yet-accepted request is locked so the slave-side request stays stable.
- Tracks outstanding transactions in an ID FIFO and routes each rvalid/err/rdata back to the master that issued it, in order.

Parameters:
DEPTH, 2, max outstanding transactions (ID FIFO depth, >=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
m_req_i  in  2  per-master request, held until granted
m_gnt_o  out  2  per-master grant
m_addr_i  in  64  {m1,m0} word-aligned addresses
m_we_i  in  2  per-master write enable
m_be_i  in  8  {m1,m0} byte enables
m_wdata_i  in  64  {m1,m0} write data
m_rvalid_o  out  2  per-master response valid
m_err_o  out  2  per-master response error
m_rdata_o  out  32  read data, shared by both masters
data_req_o  out  1  slave request
data_gnt_i  in  1  slave grant
data_addr_o  out  32  slave address
data_we_o  out  1  slave write enable
data_be_o  out  4  slave byte enables
data_wdata_o  out  32  slave write data
data_rvalid_i  in  1  slave response valid
data_err_i  in  1  slave response error
data_rdata_i  in  32  slave read data
busy_o  out  1  at least one transaction outstanding

Behaviour:
- Reset: clk_i clock; rst_ni reset, asynchronous, active-low. Clears prio_q=0 (m0 preferred), lock_q=0, lock_sel_q=0, FIFO count=0, pointers=0.
- Output values at reset: m_gnt_o=0, m_rvalid_o=0, m_err_o=0, busy_o=0, data_req_o=0 unless m_req_i!=0.
- Selection (sel):
  - If lock_q: sel=lock_sel_q.
  - Else if only one m_req_i bit is set: that master.
  - Else if both are set: sel=prio_q.
- full = (count==DEPTH).
- Slave request: data_req_o = m_req_i[sel] & ~full.
- data_addr_o/we/be/wdata are muxed from master sel, combinationally.
- m_gnt_o[sel] = data_req_o & data_gnt_i; the other grant bit is 0. Zero-latency grant, same cycle.
- Lock:
  - If data_req_o=1 and data_gnt_i=0: lock_q<=1 and lock_sel_q<=sel.
  - Cleared on the handshake cycle.
  - A locked master dropping req, which is a protocol violation, also clears the lock.
- Handshake (data_req_o & data_gnt_i):
  - Push sel into the ID FIFO.
  - prio_q <= ~sel (the other master gets priority next).
- Response:
  - When data_rvalid_i=1 and count!=0: pop the head ID h.
  - m_rvalid_o[h]=1 and m_err_o[h]=data_err_i, both the same cycle (combinational).
  - m_rdata_o = data_rdata_i always (valid only with rvalid).
- Ordering: the slave returns responses in order, no earlier than the cycle after the grant. A push and a pop in the same cycle never refer to the same entry.
- Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo DEPTH.
- Full: no bypass. A same-cycle pop does not allow a grant; the request is presented the next cycle. The lock state is preserved while full.
- rvalid with count==0: ignored; no m_rvalid_o, no state change.
- busy_o = (count!=0), registered-state based.
- Reset mid-operation: outstanding IDs are discarded and later rvalids are ignored per the rule above.

Test Plan:
- Single transaction: m_req_i=01, addr 0x1000, data_gnt_i=1 in cycle 0; rvalid with rdata 0xDEADBEEF in cycle 1 -> m_gnt_o=01 in cycle 0, m_rvalid_o=01 and m_rdata_o=0xDEADBEEF in cycle 1, busy_o=1 only in cycle 1.
- Contention: m_req_i=11 held, data_gnt_i=1 every cycle, rvalid one cycle later each -> grants m0,m1,m0,m1 alternating; m_rvalid_o=01,10,01,10.
- Lock: m_req_i=11, m0 addr 0x1000, m1 addr 0x2000, data_gnt_i=0 for 3 cycles then 1 -> data_addr_o=0x1000 for all 4 cycles, m0 granted in cycle 3, m1 granted in cycle 4.
- Full (DEPTH=2): two grants with no rvalid -> data_req_o=0 while m_req_i=11; rvalid in cycle N -> m_rvalid_o routed correctly, data_req_o=1 again in cycle N+1.
- Error routing: outstanding m1 read, data_rvalid_i=1 with data_err_i=1 -> m_rvalid_o=10, m_err_o=10, m_err_o[0]=0.
- Reset mid-operation: count=2, assert rst_ni=0 for 1 cycle, then rvalid -> busy_o=0, m_rvalid_o=00, prio_q back to m0.

Source files
------------

// File: rtl/ibex_data_bus_arbiter.sv
// Two-master round-robin arbiter for the core data port (req/gnt/rvalid).
// A small ID FIFO records the issuing master so in-order responses route back.
module ibex_data_bus_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  m_req_i,
    output logic [1:0]  m_gnt_o,
    input  logic [63:0] m_addr_i,
    input  logic [1:0]  m_we_i,
    input  logic [7:0]  m_be_i,
    input  logic [63:0] m_wdata_i,
    output logic [1:0]  m_rvalid_o,
    output logic [1:0]  m_err_o,
    output logic [31:0] m_rdata_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic        busy_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             prio_q, prio_d;
    logic             lock_q, lock_d;
    logic             lock_sel_q, lock_sel_d;
    logic [DEPTH-1:0] ids_q, ids_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic sel_s, full_s, hs_s, pop_s, head_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Master selection: a stalled request stays locked to its master.
    always_comb begin
        sel_s = prio_q;
        if (lock_q) begin
            sel_s = lock_sel_q;
        end else begin
            case (m_req_i)
                2'b01:   sel_s = 1'b0;
                2'b10:   sel_s = 1'b1;
                default: sel_s = prio_q;
            endcase
        end
    end

    assign full_s       = (cnt_q == CW'(DEPTH));
    assign data_req_o   = m_req_i[sel_s] & ~full_s;
    assign hs_s         = data_req_o & data_gnt_i;
    assign data_addr_o  = sel_s ? m_addr_i[63:32]  : m_addr_i[31:0];
    assign data_we_o    = sel_s ? m_we_i[1]        : m_we_i[0];
    assign data_be_o    = sel_s ? m_be_i[7:4]      : m_be_i[3:0];
    assign data_wdata_o = sel_s ? m_wdata_i[63:32] : m_wdata_i[31:0];

    assign pop_s     = data_rvalid_i & (cnt_q != '0);
    assign head_s    = ids_q[rptr_q];
    assign m_rdata_o = data_rdata_i;
    assign busy_o    = (cnt_q != '0);

    // Grant and response steering to the owning master.
    always_comb begin
        m_gnt_o    = 2'b00;
        m_rvalid_o = 2'b00;
        m_err_o    = 2'b00;
        if (hs_s) begin
            m_gnt_o[sel_s] = 1'b1;
        end else begin
            m_gnt_o = 2'b00;
        end
        if (pop_s) begin
            m_rvalid_o[head_s] = 1'b1;
            m_err_o[head_s]    = data_err_i;
        end else begin
            m_rvalid_o = 2'b00;
            m_err_o    = 2'b00;
        end
    end

    // Next-state for priority, lock and the ID FIFO.
    always_comb begin
        prio_d     = prio_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        ids_d      = ids_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;

        if (hs_s) begin
            lock_d        = 1'b0;
            prio_d        = ~sel_s;
            ids_d[wptr_q] = sel_s;
            wptr_d        = ptr_inc(wptr_q);
        end else if (data_req_o) begin
            lock_d     = 1'b1;
            lock_sel_d = sel_s;
        end else if (lock_q && !m_req_i[lock_sel_q]) begin
            // The locked master withdrew its request; release the lock.
            lock_d = 1'b0;
        end else begin
            lock_d = lock_q;
        end

        if (pop_s) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end

        case ({hs_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            ids_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            ids_q      <= ids_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// Randomized + directed bench for ibex_data_bus_arbiter against a queue-based
// behavioural model of the arbitration and response-routing rules.
module tb_ibex_data_bus_arbiter;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  m_req_i;
    logic [1:0]  m_gnt_o;
    logic [63:0] m_addr_i;
    logic [1:0]  m_we_i;
    logic [7:0]  m_be_i;
    logic [63:0] m_wdata_i;
    logic [1:0]  m_rvalid_o;
    logic [1:0]  m_err_o;
    logic [31:0] m_rdata_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_rdata_i;
    logic        busy_o;

    ibex_data_bus_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i),
        .m_we_i(m_we_i), .m_be_i(m_be_i), .m_wdata_i(m_wdata_i),
        .m_rvalid_o(m_rvalid_o), .m_err_o(m_err_o), .m_rdata_o(m_rdata_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
        .data_rdata_i(data_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: who is preferred, who holds a stalled request,
    // and the owners of outstanding transactions in issue order.
    int turn;
    int held;
    int held_by;
    int owners[$];
    logic [1:0] last_gnt;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        turn     = 0;
        held     = 0;
        held_by  = 0;
        last_gnt = 2'b00;
        owners.delete();
    endtask

    // Drive one cycle of inputs, compare every output against the model,
    // then advance the model to match the upcoming rising edge.
    task automatic cyc(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                       input logic g, input logic rv, input logic er, input logic [31:0] rd);
        int who, h;
        bit want, full, go, pop;
        logic [1:0] e_gnt, e_rv, e_err;
        @(negedge clk_i);
        m_req_i       = req;
        m_addr_i      = {a1, a0};
        m_we_i        = 2'($urandom);
        m_be_i        = 8'($urandom);
        m_wdata_i     = {$urandom, $urandom};
        data_gnt_i    = g;
        data_rvalid_i = rv;
        data_err_i    = er;
        data_rdata_i  = rd;
        #1;
        if (held != 0)          who = held_by;
        else if (req == 2'b01)  who = 0;
        else if (req == 2'b10)  who = 1;
        else                    who = turn;
        full  = (owners.size() == DEPTH);
        want  = req[who] && !full;
        go    = want && g;
        pop   = rv && (owners.size() != 0);
        h     = pop ? owners[0] : 0;
        e_gnt = go ? 2'(1 << who) : 2'b00;
        e_rv  = pop ? 2'(1 << h) : 2'b00;
        e_err = (pop && er) ? 2'(1 << h) : 2'b00;

        check_val("data_req", 64'(data_req_o), 64'(want));
        check_val("m_gnt", 64'(m_gnt_o), 64'(e_gnt));
        check_val("m_rvalid", 64'(m_rvalid_o), 64'(e_rv));
        check_val("m_err", 64'(m_err_o), 64'(e_err));
        check_val("busy", 64'(busy_o), 64'(owners.size() != 0));
        if (pop) check_val("m_rdata", 64'(m_rdata_o), 64'(rd));
        if (want) begin
            check_val("data_addr", 64'(data_addr_o), 64'(who ? a1 : a0));
            check_val("data_we", 64'(data_we_o), 64'(m_we_i[who]));
            check_val("data_be", 64'(data_be_o), 64'(who ? m_be_i[7:4] : m_be_i[3:0]));
            check_val("data_wdata", 64'(data_wdata_o),
                      64'(who ? m_wdata_i[63:32] : m_wdata_i[31:0]));
        end

        if (pop) void'(owners.pop_front());
        if (go) begin
            owners.push_back(who);
            turn = 1 - who;
            held = 0;
        end else if (want) begin
            held    = 1;
            held_by = who;
        end else if (held != 0 && !req[held_by]) begin
            held = 0;
        end
        last_gnt = e_gnt;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        m_req_i = 2'b00; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
        #1;
        check_val("rst_gnt", 64'(m_gnt_o), 64'd0);
        check_val("rst_rvalid", 64'(m_rvalid_o), 64'd0);
        check_val("rst_err", 64'(m_err_o), 64'd0);
        check_val("rst_busy", 64'(busy_o), 64'd0);
        check_val("rst_req", 64'(data_req_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    logic [1:0]  rq;
    logic [31:0] ra0, ra1;

    initial begin
        rst_ni = 1'b0;
        m_req_i = 2'b00; m_addr_i = 64'd0; m_we_i = 2'b00; m_be_i = 8'd0; m_wdata_i = 64'd0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'd0;
        model_reset();
        do_reset();

        // Single transaction
        cyc(2'b01, 32'h1000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(2'b00, 32'h1000, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        check_val("single_rdata", 64'(m_rdata_o), 64'h0000_0000_DEAD_BEEF);
        check_val("single_rvalid", 64'(m_rvalid_o), 64'h1);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Contention: alternating grants, responses one cycle later
        cyc(2'b11, 32'h1000, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++)
            cyc(2'b11, 32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 32'(i));
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h55);

        // Lock: stalled m0 request held 3 cycles, then m0 and m1 granted
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(2'b11, 32'h1000, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0);
            check_val("lock_addr", 64'(data_addr_o), 64'h1000);
        end
        cyc(2'b11, 32'h1000, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("lock_gnt_m0", 64'(m_gnt_o), 64'h1);
        cyc(2'b10, 32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 32'h0);
        check_val("lock_gnt_m1", 64'(m_gnt_o), 64'h2);

        // Full: third request blocked until a response, then re-presented
        cyc(2'b11, 32'h3000, 32'h4000, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(2'b11, 32'h3000, 32'h4000, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("full_req", 64'(data_req_o), 64'h0);
        cyc(2'b11, 32'h3000, 32'h4000, 1'b1, 1'b1, 1'b0, 32'h11);
        check_val("full_pop_req", 64'(data_req_o), 64'h0);
        cyc(2'b11, 32'h3000, 32'h4000, 1'b1, 1'b1, 1'b0, 32'h22);
        check_val("full_reissue", 64'(data_req_o), 64'h1);

        // Error routing to m1
        do_reset();
        cyc(2'b10, 32'h0, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hBAD);
        check_val("err_m1", 64'(m_err_o), 64'h2);

        // Reset mid-operation with two outstanding
        cyc(2'b11, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(2'b11, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0);
        do_reset();
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h77);
        check_val("rst_stale_rv", 64'(m_rvalid_o), 64'h0);
        cyc(2'b11, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("rst_prio_m0", 64'(m_gnt_o), 64'h1);

        // Randomized traffic; masters hold requests until granted
        rq = 2'b00; ra0 = 32'h0; ra1 = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!rq[m] || last_gnt[m]) begin
                    rq[m] = ($urandom_range(0, 1) == 1);
                    if (m == 0) ra0 = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                    else        ra1 = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                end else if ($urandom_range(0, 31) == 0) begin
                    rq[m] = 1'b0;
                end
            end
            cyc(rq, ra0, ra1, ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 3) == 0), $urandom);
            if (i == 1500) begin
                do_reset();
                rq = 2'b00;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
